// File: rtl/value_deliver_tx_ctrl_if.sv
// Handshake bundle between a local producer / CDC deliver path and value_deliver_tx_ctrl.
// master: the environment side (producer and returning acknowledge); slave: the controller.
interface value_deliver_tx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req_vld;
    logic [WIDTH-1:0] req_value;
    logic             req_rdy;
    logic             pulse_out;
    logic [WIDTH-1:0] value_out;
    logic             ack_in;
    logic             busy;
    logic             done;
    logic             timeout_err;

    modport master (
        output req_vld, req_value, ack_in,
        input  req_rdy, pulse_out, value_out, busy, done, timeout_err
    );

    modport slave (
        input  req_vld, req_value, ack_in,
        output req_rdy, pulse_out, value_out, busy, done, timeout_err
    );
endinterface

// File: rtl/value_deliver_tx_ctrl.sv
// Source-side controller for the pulse/value CDC path: one transfer in flight, ack timeout.
// Optional feature macro VALUE_DELIVER_RETRY_EN: up to 3 re-pulses before timeout_err.
module value_deliver_tx_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    value_deliver_tx_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_HOLD} state_t;

    // Counter holds k-1 in the k-th WAIT cycle, so matching TIMEOUT-2 lands the
    // error pulse exactly TIMEOUT cycles after the launch pulse.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);
    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam state_t     S_AFTER  = (GAP > 0) ? S_HOLD : S_IDLE;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [3:0]       r_gap;
    logic [WIDTH-1:0] r_value;
    logic             r_pulse;
    logic             r_done;
    logic             r_terr;

    logic w_accept;
    logic w_expire;
    logic w_retry;

    assign w_accept = (r_state == S_IDLE) && bus.req_vld;
    assign w_expire = (r_state == S_WAIT) && !bus.ack_in && (r_cnt == CNT_LAST);

`ifdef VALUE_DELIVER_RETRY_EN
    logic [1:0] r_retry;

    assign w_retry = w_expire && (r_retry != 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry <= 2'd0;
        end else if (w_accept) begin
            r_retry <= 2'd0;
        end else if (w_retry) begin
            r_retry <= r_retry + 2'd1;
        end
    end
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_gap   <= 4'd0;
            r_value <= '0;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_value <= bus.req_value;
                        r_pulse <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    r_gap <= 4'd0;
                    // An ack in the expiry cycle takes priority over the timeout.
                    if (bus.ack_in) begin
                        r_done  <= 1'b1;
                        r_state <= S_AFTER;
                    end else if (w_retry) begin
                        r_pulse <= 1'b1;
                        r_state <= S_SEND;
                    end else if (w_expire) begin
                        r_terr  <= 1'b1;
                        r_state <= S_AFTER;
                    end
                end
                S_HOLD: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_rdy     = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.pulse_out   = r_pulse;
    assign bus.value_out   = r_value;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_value_deliver_tx_ctrl.sv
// Directed bench for value_deliver_tx_ctrl (WIDTH=8, TIMEOUT=64, GAP=2).
// Retry scenarios are exercised only when VALUE_DELIVER_RETRY_EN is defined.
module tb_value_deliver_tx_ctrl;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int GAP     = 2;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    value_deliver_tx_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

    value_deliver_tx_ctrl #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT),
        .GAP    (GAP)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [7:0] val);
        chk({tag, "_rdy"},   32'(bus_if.req_rdy),     32'd1);
        chk({tag, "_busy"},  32'(bus_if.busy),        32'd0);
        chk({tag, "_pulse"}, 32'(bus_if.pulse_out),   32'd0);
        chk({tag, "_done"},  32'(bus_if.done),        32'd0);
        chk({tag, "_terr"},  32'(bus_if.timeout_err), 32'd0);
        chk({tag, "_val"},   32'(bus_if.value_out),   32'(val));
    endtask

    // Issue a request from IDLE; returns in the launch (pulse_out) cycle.
    task automatic launch(input string tag, input logic [7:0] val);
        bus_if.req_vld   = 1'b1;
        bus_if.req_value = val;
        tick();
        bus_if.req_vld   = 1'b0;
        bus_if.req_value = 8'h00;
        chk({tag, "_pulse"}, 32'(bus_if.pulse_out), 32'd1);
        chk({tag, "_val"},   32'(bus_if.value_out), 32'(val));
        chk({tag, "_busy"},  32'(bus_if.busy),      32'd1);
    endtask

    // Advance n cycles; count activity on pulse_out / done / timeout_err.
    task automatic quiet_ticks(input int n, output int pulses, output int events);
        pulses = 0;
        events = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus_if.pulse_out) pulses++;
            if (bus_if.done || bus_if.timeout_err) events++;
        end
    endtask

    initial begin
        int p;
        int e;
        n_chk = 0;
        n_pass = 0;
        rst_n            = 1'b0;
        bus_if.req_vld   = 1'b0;
        bus_if.req_value = 8'h00;
        bus_if.ack_in    = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset", 8'h00);
        rst_n = 1'b1;

        // Basic delivery: ack in second WAIT cycle, rdy returns GAP cycles after done.
        launch("t1", 8'hA5);
        tick();
        chk("t1_wait_pulse", 32'(bus_if.pulse_out), 32'd0);
        tick();
        bus_if.ack_in = 1'b1;
        tick();
        bus_if.ack_in = 1'b0;
        chk("t1_done",      32'(bus_if.done),    32'd1);
        chk("t1_rdy_hold",  32'(bus_if.req_rdy), 32'd0);
        tick();
        chk("t1_done_once", 32'(bus_if.done),    32'd0);
        chk("t1_rdy_hold2", 32'(bus_if.req_rdy), 32'd0);
        tick();
        chk_idle_outputs("t1_idle", 8'hA5);

        // Stray ack in IDLE.
        bus_if.ack_in = 1'b1;
        tick();
        bus_if.ack_in = 1'b0;
        chk_idle_outputs("stray_idle", 8'hA5);

`ifndef VALUE_DELIVER_RETRY_EN
        // Timeout with no ack: single error pulse TIMEOUT cycles after launch.
        launch("t2", 8'hA5);
        quiet_ticks(TIMEOUT - 1, p, e);
        chk("t2_no_early_pulse", 32'(p), 32'd0);
        chk("t2_no_early_event", 32'(e), 32'd0);
        tick();
        chk("t2_terr",  32'(bus_if.timeout_err), 32'd1);
        chk("t2_done0", 32'(bus_if.done),        32'd0);
        chk("t2_busy",  32'(bus_if.busy),        32'd1);
        tick();
        chk("t2_terr_once", 32'(bus_if.timeout_err), 32'd0);
        chk("t2_busy_hold", 32'(bus_if.busy),        32'd1);
        tick();
        chk_idle_outputs("t2_idle", 8'hA5);
`endif

        // Ack arriving in the expiry cycle wins over the timeout.
        launch("t3", 8'h77);
        quiet_ticks(TIMEOUT - 2, p, e);
        chk("t3_no_early_event", 32'(e), 32'd0);
        chk("t3_busy_pre",       32'(bus_if.busy), 32'd1);
        tick();
        chk("t3_last_wait_quiet", 32'(bus_if.done | bus_if.timeout_err), 32'd0);
        bus_if.ack_in = 1'b1;
        tick();
        chk("t3_done", 32'(bus_if.done),        32'd1);
        chk("t3_terr", 32'(bus_if.timeout_err), 32'd0);
        // Stray ack during HOLD.
        tick();
        bus_if.ack_in = 1'b0;
        chk("t3_stray_hold_done", 32'(bus_if.done), 32'd0);
        chk("t3_stray_hold_busy", 32'(bus_if.busy), 32'd1);
        chk("t3_stray_hold_terr", 32'(bus_if.timeout_err), 32'd0);
        tick();
        chk_idle_outputs("t3_idle", 8'h77);

`ifdef VALUE_DELIVER_RETRY_EN
        // Retry: four launches TIMEOUT apart, then timeout_err.
        launch("r1_p1", 8'h3C);
        for (int r = 2; r <= 4; r++) begin
            quiet_ticks(TIMEOUT - 1, p, e);
            chk("r1_gap_quiet", 32'(p + e), 32'd0);
            tick();
            chk("r1_repulse", 32'(bus_if.pulse_out), 32'd1);
            chk("r1_reval",   32'(bus_if.value_out), 32'h3C);
        end
        quiet_ticks(TIMEOUT - 1, p, e);
        chk("r1_final_quiet", 32'(p + e), 32'd0);
        tick();
        chk("r1_terr", 32'(bus_if.timeout_err), 32'd1);
        tick();
        tick();
        chk_idle_outputs("r1_idle", 8'h3C);

        // Retry with ack after the second launch: exactly two pulses.
        launch("r2_p1", 8'h3C);
        quiet_ticks(TIMEOUT - 1, p, e);
        tick();
        chk("r2_p2", 32'(bus_if.pulse_out), 32'd1);
        tick();
        bus_if.ack_in = 1'b1;
        tick();
        bus_if.ack_in = 1'b0;
        chk("r2_done", 32'(bus_if.done), 32'd1);
        quiet_ticks(2 * TIMEOUT, p, e);
        chk("r2_no_more_pulses", 32'(p), 32'd0);
        chk("r2_no_more_events", 32'(e), 32'd0);
        chk_idle_outputs("r2_idle", 8'h3C);
`endif

        // Asynchronous reset in WAIT, later stray ack, then a clean transfer.
        launch("t4", 8'h22);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t4_rst", 8'h00);
        #2;
        rst_n = 1'b1;
        bus_if.ack_in = 1'b1;
        tick();
        bus_if.ack_in = 1'b0;
        chk_idle_outputs("t4_stray", 8'h00);
        launch("t4_new", 8'h11);
        tick();
        bus_if.ack_in = 1'b1;
        tick();
        bus_if.ack_in = 1'b0;
        chk("t4_new_done", 32'(bus_if.done), 32'd1);
        tick();
        tick();
        chk_idle_outputs("t4_new_idle", 8'h11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
